dadda_mult_sched: RTL and testbench

//  Shares one combinational Dadda multiplier between two requesters.

---
 rtl/dadda_pkg.sv | 36 +++
 rtl/dadda_mult_sched_if.sv | 28 ++
 rtl/dadda_multiplier.sv | 116 +++++++++++
 rtl/dadda_mult_sched.sv | 122 ++++++++++++
 tb/tb_dadda_mult_sched.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dadda_pkg.sv
// Shared types and helpers for the shared Dadda multiplier scheduler.
// Holds the FSM state encoding, requester count and Dadda stage-height helpers.
package dadda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NREQ  = 2;
  localparam int CNT_W = 4;

  // Dadda target height for stage s: d1 = 2, d(s+1) = floor(1.5 * d(s))
  function automatic int dadda_height(input int s);
    int d;
    d = 2;
    for (int i = 1; i < s; i++) begin
      d = (d * 3) / 2;
    end
    return d;
  endfunction

  // Number of reduction stages: index of the largest target height below w
  function automatic int dadda_stages(input int w);
    int s;
    s = 0;
    for (int i = 1; i < 32; i++) begin
      if (dadda_height(i) < w) begin
        s = i;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/dadda_mult_sched_if.sv
// Operand request / result handshake bundle between the requesters and the
// shared multiplier scheduler.
interface dadda_mult_sched_if #(
  parameter int W = 8
);
  import dadda_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [2*W-1:0]    res_data;
  logic              res_id;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/dadda_multiplier.sv
// Combinational unsigned W x W Dadda multiplier: partial-product columns are
// compressed stage by stage to two rows, then summed by a final adder.
module dadda_multiplier
  import dadda_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam int PW = 2 * W;
  localparam int MH = W + 1;
  localparam int NS = dadda_stages(W);

  logic [PW-1:0] row0_s;
  logic [PW-1:0] row1_s;

  // Column compression: each stage squeezes every column to the stage target height
  always_comb begin : reduce_p
    logic [MH-1:0] cur_v [PW];
    logic [MH-1:0] nxt_v [PW];
    int            cur_h [PW];
    int            nxt_h [PW];
    int            k;
    int            d;
    int            r;
    logic          x0;
    logic          x1;
    logic          x2;

    k  = 0;
    d  = 0;
    r  = 0;
    x0 = 1'b0;
    x1 = 1'b0;
    x2 = 1'b0;
    for (int i = 0; i < PW; i++) begin
      cur_v[i] = '0;
      nxt_v[i] = '0;
      cur_h[i] = 0;
      nxt_h[i] = 0;
    end

    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        cur_v[i+j][cur_h[i+j]] = a[i] & b[j];
        cur_h[i+j] = cur_h[i+j] + 1;
      end
    end

    for (int s = NS; s >= 1; s--) begin
      d = dadda_height(s);
      for (int i = 0; i < PW; i++) begin
        nxt_v[i] = '0;
        nxt_h[i] = 0;
      end
      // Columns go LSB first so carries from column i-1 already count against column i
      for (int i = 0; i < PW; i++) begin
        k = 0;
        for (int f = 0; f < MH; f++) begin
          r = cur_h[i] - k;
          if ((r + nxt_h[i] - d >= 2) && (r >= 3)) begin
            x0 = cur_v[i][k];
            x1 = cur_v[i][k+1];
            x2 = cur_v[i][k+2];
            nxt_v[i][nxt_h[i]] = x0 ^ x1 ^ x2;
            nxt_h[i] = nxt_h[i] + 1;
            if (i + 1 < PW) begin
              nxt_v[i+1][nxt_h[i+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
              nxt_h[i+1] = nxt_h[i+1] + 1;
            end else begin
              nxt_h[i] = nxt_h[i];
            end
            k = k + 3;
          end else if ((r + nxt_h[i] - d >= 1) && (r >= 2)) begin
            x0 = cur_v[i][k];
            x1 = cur_v[i][k+1];
            nxt_v[i][nxt_h[i]] = x0 ^ x1;
            nxt_h[i] = nxt_h[i] + 1;
            if (i + 1 < PW) begin
              nxt_v[i+1][nxt_h[i+1]] = x0 & x1;
              nxt_h[i+1] = nxt_h[i+1] + 1;
            end else begin
              nxt_h[i] = nxt_h[i];
            end
            k = k + 2;
          end else begin
            k = k;
          end
        end
        for (int f = 0; f < MH; f++) begin
          if ((f >= k) && (f < cur_h[i])) begin
            nxt_v[i][nxt_h[i]] = cur_v[i][f];
            nxt_h[i] = nxt_h[i] + 1;
          end else begin
            k = k;
          end
        end
      end
      for (int i = 0; i < PW; i++) begin
        cur_v[i] = nxt_v[i];
        cur_h[i] = nxt_h[i];
      end
    end

    for (int i = 0; i < PW; i++) begin
      row0_s[i] = cur_v[i][0];
      row1_s[i] = cur_v[i][1];
    end
  end

  assign p = row0_s + row1_s;

endmodule

// File: rtl/dadda_mult_sched.sv
// Scheduler sharing one Dadda multiplier between two requesters: round-robin
// grant, operand capture, settle-wait counter and back-pressured result register.
module dadda_mult_sched
  import dadda_pkg::*;
#(
  parameter int W       = 8,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dadda_mult_sched_if.slave bus
);

  localparam logic [1:0]       ST_IDLE  = IDLE;
  localparam logic [1:0]       ST_CALC  = CALC;
  localparam logic [1:0]       ST_DONE  = DONE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rr_ptr_r;
  logic [W-1:0]     op_a_r;
  logic [W-1:0]     op_b_r;
  logic             id_r;
  logic             res_valid_r;
  logic [2*W-1:0]   res_data_r;
  logic             res_id_r;

  logic             take_s;
  logic             gnt_s;
  logic [W-1:0]     sel_a_s;
  logic [W-1:0]     sel_b_s;
  logic [2*W-1:0]   prod_s;

  // Round-robin grant; only offered in IDLE and never while reset is asserted
  always_comb begin
    take_s = 1'b0;
    gnt_s  = 1'b0;
    if (rst_n && (state_r == ST_IDLE)) begin
      if (bus.req_valid[rr_ptr_r]) begin
        take_s = 1'b1;
        gnt_s  = rr_ptr_r;
      end else if (bus.req_valid[~rr_ptr_r]) begin
        take_s = 1'b1;
        gnt_s  = ~rr_ptr_r;
      end else begin
        take_s = 1'b0;
        gnt_s  = 1'b0;
      end
    end else begin
      take_s = 1'b0;
      gnt_s  = 1'b0;
    end
  end

  assign bus.req_ready = {take_s & gnt_s, take_s & ~gnt_s};
  assign sel_a_s       = gnt_s ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
  assign sel_b_s       = gnt_s ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];

  dadda_multiplier #(
    .W (W)
  ) u_mul (
    .a (op_a_r),
    .b (op_b_r),
    .p (prod_s)
  );

  // Issue / settle / hold sequencing; rr_ptr only moves when a result retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      rr_ptr_r    <= 1'b0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      id_r        <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_id_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            op_a_r  <= sel_a_s;
            op_b_r  <= sel_b_s;
            id_r    <= gnt_s;
            cnt_r   <= '0;
            state_r <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (cnt_r == LAST_CNT) begin
            res_data_r  <= prod_s;
            res_id_r    <= id_r;
            res_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            rr_ptr_r    <= ~id_r;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_id    = res_id_r;
  assign bus.busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dadda_mult_sched.sv
// Directed bench for dadda_mult_sched: MUL_LAT=1 and MUL_LAT=3 instances share
// one stimulus set, with sel choosing which instance is driven and observed.
module tb_dadda_mult_sched;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [1:0]  t_req_valid;
  logic [15:0] t_req_a;
  logic [15:0] t_req_b;
  logic        t_res_ready;

  logic [1:0]  o_req_ready;
  logic        o_res_valid;
  logic [15:0] o_res_data;
  logic        o_res_id;
  logic        o_busy;

  int checks;
  int errors;

  dadda_mult_sched_if #(.W(8)) bif1 ();
  dadda_mult_sched_if #(.W(8)) bif3 ();

  dadda_mult_sched #(.W(8), .MUL_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1));
  dadda_mult_sched #(.W(8), .MUL_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bif3));

  assign bif1.req_valid = sel ? 2'b00 : t_req_valid;
  assign bif3.req_valid = sel ? t_req_valid : 2'b00;
  assign bif1.req_a     = t_req_a;
  assign bif3.req_a     = t_req_a;
  assign bif1.req_b     = t_req_b;
  assign bif3.req_b     = t_req_b;
  assign bif1.res_ready = t_res_ready;
  assign bif3.res_ready = t_res_ready;

  assign o_req_ready = sel ? bif3.req_ready : bif1.req_ready;
  assign o_res_valid = sel ? bif3.res_valid : bif1.res_valid;
  assign o_res_data  = sel ? bif3.res_data  : bif1.res_data;
  assign o_res_id    = sel ? bif3.res_id    : bif1.res_id;
  assign o_busy      = sel ? bif3.busy      : bif1.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    t_req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One request through to retirement with res_ready held high
  task automatic do_op(input logic [1:0] vld, input logic idx, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp, input string tag);
    int n;
    int lat_exp;
    lat_exp = sel ? 3 : 1;
    if (idx) begin
      t_req_a[15:8] = a;
      t_req_b[15:8] = b;
    end else begin
      t_req_a[7:0] = a;
      t_req_b[7:0] = b;
    end
    t_res_ready = 1'b1;
    t_req_valid = vld;
    #1;
    n = 0;
    while (o_req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_rdy"}, o_req_ready, idx ? 2'b10 : 2'b01);
    @(negedge clk);
    t_req_valid = 2'b00;
    n = 0;
    while (!o_res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat_exp);
    chk({tag, "_data"}, o_res_data, exp);
    chk({tag, "_id"}, o_res_id, idx);
    @(negedge clk);
    chk({tag, "_retired"}, o_res_valid, 1'b0);
    chk({tag, "_hold"}, o_res_data, exp);
  endtask

  initial begin
    int n;
    int got;
    logic exp_id;
    checks = 0;
    errors = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    t_req_valid = 2'($urandom);
    t_req_a = 16'($urandom);
    t_req_b = 16'($urandom);
    t_res_ready = 1'($urandom);

    // Reset state with random inputs applied
    repeat (3) @(negedge clk);
    chk("rst_valid", o_res_valid, 1'b0);
    chk("rst_data", o_res_data, 16'h0000);
    chk("rst_id", o_res_id, 1'b0);
    chk("rst_ready", o_req_ready, 2'b00);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_valid3", bif3.res_valid, 1'b0);
    rst_n = 1'b1;
    t_req_valid = 2'b00;
    t_res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ready", o_req_ready, 2'b00);
      chk("idle_busy", o_busy, 1'b0);
    end

    // Single op
    do_op(2'b01, 1'b0, 8'h0D, 8'h0B, 16'h008F, "single");

    // Contention: grants alternate starting at requester 0 after reset
    do_reset();
    t_req_a = {8'h07, 8'h03};
    t_req_b = {8'h09, 8'h05};
    t_res_ready = 1'b1;
    t_req_valid = 2'b11;
    exp_id = 1'b0;
    got = 0;
    n = 0;
    while (got < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (o_res_valid) begin
        chk("ct_id", o_res_id, exp_id);
        chk("ct_data", o_res_data, exp_id ? 32'd63 : 32'd15);
        exp_id = ~exp_id;
        got++;
      end
    end
    chk("ct_count", got, 6);
    t_req_valid = 2'b00;
    @(negedge clk);
    chk("ct_idle", o_busy, 1'b0);

    // Back-pressure: requester 1 result held while res_ready is low
    t_res_ready = 1'b0;
    t_req_a[15:8] = 8'h12;
    t_req_b[15:8] = 8'h34;
    t_req_valid = 2'b10;
    n = 0;
    while (!o_res_valid && n < 20) begin
      @(negedge clk);
      if (o_busy) t_req_valid = 2'b11;
      n++;
    end
    chk("bp_seen", o_res_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_valid", o_res_valid, 1'b1);
      chk("bp_data", o_res_data, 16'h03A8);
      chk("bp_id", o_res_id, 1'b1);
      chk("bp_ready", o_req_ready, 2'b00);
      @(negedge clk);
    end
    t_res_ready = 1'b1;
    t_req_valid = 2'b00;
    @(negedge clk);
    chk("bp_retire", o_res_valid, 1'b0);

    // Extremes at MUL_LAT=1
    do_op(2'b01, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "max");
    do_op(2'b01, 1'b0, 8'h00, 8'hFF, 16'h0000, "zero");
    do_op(2'b01, 1'b0, 8'h01, 8'hA5, 16'h00A5, "one");

    // Same checks on the MUL_LAT=3 instance
    sel = 1'b1;
    do_op(2'b01, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "l3_max");
    do_op(2'b10, 1'b1, 8'h0C, 8'h0D, 16'h009C, "l3_r1");
    sel = 1'b0;

    // Reset while in CALC; pointer was 1 before reset and must return to 0
    t_req_a[15:8] = 8'h02;
    t_req_b[15:8] = 8'h03;
    t_res_ready = 1'b1;
    t_req_valid = 2'b10;
    #1;
    chk("c_rdy", o_req_ready, 2'b10);
    @(negedge clk);
    t_req_valid = 2'b00;
    #1;
    chk("c_busy", o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("c_rst_busy", o_busy, 1'b0);
    chk("c_rst_valid", o_res_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b11, 1'b0, 8'h11, 8'h0F, 16'h00FF, "c_after");

    // Reset while in DONE with a held result
    t_res_ready = 1'b0;
    t_req_a[7:0] = 8'h20;
    t_req_b[7:0] = 8'h04;
    t_req_valid = 2'b01;
    n = 0;
    while (!o_res_valid && n < 20) begin
      @(negedge clk);
      if (o_busy) t_req_valid = 2'b00;
      n++;
    end
    chk("d_seen", o_res_valid, 1'b1);
    chk("d_data", o_res_data, 16'h0080);
    rst_n = 1'b0;
    #1;
    chk("d_rst_valid", o_res_valid, 1'b0);
    chk("d_rst_data", o_res_data, 16'h0000);
    chk("d_rst_id", o_res_id, 1'b0);
    chk("d_rst_busy", o_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b11, 1'b0, 8'h07, 8'h06, 16'h002A, "d_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
